commit_controller: RTL and testbench
====================================

Name: commit_controller

Overview:
- Sequences in-order retirement from the ROB head into register_file.
- Forwards decoder rename requests (dependency set) into register_file.
- On a mispredicted head, orders the final writeback, the dependency clear and the fetch redirect so that no architectural write is lost to `clear`.
- Sits between rob, decoder, register_file and the fetch unit.

Parameters:
ROB_W, 4, width of ROB index (matches `robsize`)
FLUSH_CYCLES, 2, number of cycles `clear` is held asserted (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
rdy  in  1  global ready; 0 freezes the block
head_valid  in  1  ROB head entry present
head_ready  in  1  ROB head result available
head_rob_id  in  ROB_W  ROB index of head
head_writes_rd  in  1  head instruction writes rd
head_rd  in  5  destination register
head_value  in  32  result value
head_mispredict  in  1  head is a mispredicted branch or jump
head_target_pc  in  32  correct PC for a mispredicted head
commit_ack  out  1  head retired this cycle (ROB pops)
ren_valid  in  1  decoder rename request
ren_rd  in  5  renamed destination register
ren_rob_id  in  ROB_W  ROB index allocated to the request
ren_ready  out  1  rename accepted this cycle
need_set_reg_value  out  1  regfile value write strobe
set_value_reg_id  out  5  write register
set_val  out  32  write value
set_reg_rob_id  out  ROB_W  ROB id of the writer
need_set_reg_dep  out  1  regfile dependency-set strobe
set_dep_reg_id  out  5  dependency register
set_dep_rob_id  out  ROB_W  dependency ROB id
clear  out  1  regfile dependency clear
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  32  redirect target
flushing  out  1  block is in MISP_WB or FLUSH
commit_count  out  32  retired-instruction counter

Behaviour:
- Reset (rst==0 at posedge):
  - state=RUN.
  - All registered outputs 0.
  - commit_count=0.
  - Flush counter 0.
  - Reset mid-flush aborts the flush; `clear` is 0 on the following cycle.
- rdy==0:
  - No state, counter or output register changes; registered pulses hold their value.
  - commit_ack=0 and ren_ready=0.
- States:
  - RUN: normal operation.
  - MISP_WB: one cycle; the mispredicted head's write is issued.
  - FLUSH: FLUSH_CYCLES cycles.
- Commit in RUN:
  - commit_ack = rdy && state==RUN && head_valid && head_ready (combinational).
  - At that edge, commit_count increments by 1 (wraps mod 2^32).
  - If head_writes_rd && head_rd!=0: the next cycle shows need_set_reg_value=1 with set_value_reg_id/set_val/set_reg_rob_id = head_rd/head_value/head_rob_id, a single-cycle pulse.
  - If head_rd==0 or !head_writes_rd: no write strobe, but the commit still counts.
- Mispredict:
  - A committed head with head_mispredict=1 moves RUN->MISP_WB.
  - Its write (if any) appears during MISP_WB with clear=0.
  - MISP_WB->FLUSH unconditionally.
  - In FLUSH: clear=1 every cycle; redirect_valid=1 with redirect_pc=latched head_target_pc on the first FLUSH cycle only.
  - After FLUSH_CYCLES cycles, FLUSH->RUN; clear=0 from the first RUN cycle.
- Rename:
  - ren_ready = rdy && state==RUN (combinational).
  - When ren_valid && ren_ready && ren_rd!=0, the next cycle shows need_set_reg_dep=1 with set_dep_reg_id=ren_rd and set_dep_rob_id=ren_rob_id, a single-cycle pulse.
  - ren_rd==0 is accepted but produces no strobe.
  - Requests are never buffered; the decoder holds ren_valid until accepted.
- Simultaneous commit and rename, including the same rd: both strobes are issued in the same cycle. register_file resolves the ordering (the new dependency wins).
- A rename accepted in the same cycle as a mispredict commit is younger than the branch; its dependency is wiped by the subsequent `clear`.
- No value or dependency strobes are issued during FLUSH.
- flushing=1 in MISP_WB and FLUSH.
- Latency: commit or rename to regfile strobe = 1 cycle. Mispredict commit to first `clear` = 2 cycles.

Decomposition:
- Shared const package: ROB_W (from `robsize`), the state encoding (RUN=0, MISP_WB=1, FLUSH=2), and the register-zero index constant.
- No sub-module: a single FSM plus output registers.

Test Plan:
- Reset: hold rst=0 for 3 cycles with traffic on all inputs -> all outputs 0, commit_count=0; release -> ren_ready=1 when rdy=1.
- Normal commit: head rd=5, value 0xDEADBEEF, rob_id 3, ready -> commit_ack same cycle; next cycle need_set_reg_value=1, reg 5, val 0xDEADBEEF, rob 3; commit_count=1.
- x0 and no-rd: commit head_rd=0 value 7, then head_writes_rd=0 -> two acks, no write strobe, commit_count=2.
- Mispredict: jalr head rd=1 value 0x100, target 0x2000, FLUSH_CYCLES=2 -> write to rd 1 with clear=0; then clear=1 for 2 cycles; redirect_valid+0x2000 on the first clear cycle only; commit_ack and ren_ready stay 0 throughout.
- Same-rd collision: commit rd=7 rob 2 and rename rd=7 rob 9 in the same cycle -> next cycle both strobes asserted with rob ids 2 and 9.
- rdy stall and reset during flush: drop rdy in FLUSH for 3 cycles -> clear held and the flush counter frozen; then assert rst=0 -> next cycle clear=0, state RUN.

Source files
------------

// File: rtl/commit_controller_pkg.sv
// Shared constants and types for the commit controller: ROB index width,
// FSM state encoding and the hard-wired zero register.
package commit_controller_pkg;

    localparam int ROB_W = 4;  // matches robsize

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MISP_WB = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    // x0 is hard-wired, so only non-zero destinations reach the register file.
    function automatic logic writes_arch_reg(input logic writes_rd, input logic [4:0] rd);
        return writes_rd && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/commit_controller_if.sv
// Bundle of ROB head, decoder rename, register-file and fetch-redirect signals
// around the commit controller; master is the controller's view.
interface commit_controller_if #(
    parameter int ROB_W = commit_controller_pkg::ROB_W
) ();

    logic             rdy;

    logic             head_valid;
    logic             head_ready;
    logic [ROB_W-1:0] head_rob_id;
    logic             head_writes_rd;
    logic [4:0]       head_rd;
    logic [31:0]      head_value;
    logic             head_mispredict;
    logic [31:0]      head_target_pc;
    logic             commit_ack;

    logic             ren_valid;
    logic [4:0]       ren_rd;
    logic [ROB_W-1:0] ren_rob_id;
    logic             ren_ready;

    logic             need_set_reg_value;
    logic [4:0]       set_value_reg_id;
    logic [31:0]      set_val;
    logic [ROB_W-1:0] set_reg_rob_id;
    logic             need_set_reg_dep;
    logic [4:0]       set_dep_reg_id;
    logic [ROB_W-1:0] set_dep_rob_id;
    logic             clear;

    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flushing;
    logic [31:0]      commit_count;

    modport master (
        input  rdy,
        input  head_valid, head_ready, head_rob_id, head_writes_rd, head_rd,
        input  head_value, head_mispredict, head_target_pc,
        output commit_ack,
        input  ren_valid, ren_rd, ren_rob_id,
        output ren_ready,
        output need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id,
        output need_set_reg_dep, set_dep_reg_id, set_dep_rob_id, clear,
        output redirect_valid, redirect_pc, flushing, commit_count
    );

    modport slave (
        output rdy,
        output head_valid, head_ready, head_rob_id, head_writes_rd, head_rd,
        output head_value, head_mispredict, head_target_pc,
        input  commit_ack,
        output ren_valid, ren_rd, ren_rob_id,
        input  ren_ready,
        input  need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id,
        input  need_set_reg_dep, set_dep_reg_id, set_dep_rob_id, clear,
        input  redirect_valid, redirect_pc, flushing, commit_count
    );

endinterface

// File: rtl/commit_controller.sv
// In-order retirement and rename forwarding into the register file; on a
// mispredicted head: final writeback, then dependency clear plus fetch redirect.
module commit_controller #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    commit_controller_if.master  bus
);
    import commit_controller_pkg::*;

    localparam int               CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] flush_cnt;
    logic [31:0]      target_pc;
    logic             run;
    logic             commit;

    // Handshakes are withheld while in reset so the ROB and decoder never advance.
    assign run            = rst && bus.rdy && (state == RUN);
    assign commit         = run && bus.head_valid && bus.head_ready;
    assign bus.commit_ack = commit;
    assign bus.ren_ready  = run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                  <= RUN;
            flush_cnt              <= '0;
            target_pc              <= '0;
            bus.need_set_reg_value <= 1'b0;
            bus.set_value_reg_id   <= '0;
            bus.set_val            <= '0;
            bus.set_reg_rob_id     <= '0;
            bus.need_set_reg_dep   <= 1'b0;
            bus.set_dep_reg_id     <= '0;
            bus.set_dep_rob_id     <= '0;
            bus.clear              <= 1'b0;
            bus.redirect_valid     <= 1'b0;
            bus.redirect_pc        <= '0;
            bus.flushing           <= 1'b0;
            bus.commit_count       <= '0;
        end else if (bus.rdy) begin
            bus.need_set_reg_value <= 1'b0;
            bus.need_set_reg_dep   <= 1'b0;
            bus.redirect_valid     <= 1'b0;
            case (state)
                RUN: begin
                    if (commit) begin
                        bus.commit_count <= bus.commit_count + 32'd1;
                        if (writes_arch_reg(bus.head_writes_rd, bus.head_rd)) begin
                            bus.need_set_reg_value <= 1'b1;
                            bus.set_value_reg_id   <= bus.head_rd;
                            bus.set_val            <= bus.head_value;
                            bus.set_reg_rob_id     <= bus.head_rob_id;
                        end
                        if (bus.head_mispredict) begin
                            state        <= MISP_WB;
                            bus.flushing <= 1'b1;
                            target_pc    <= bus.head_target_pc;
                        end
                    end
                    // A rename beside a mispredict commit is younger; the flush wipes it.
                    if (bus.ren_valid && (bus.ren_rd != REG_ZERO)) begin
                        bus.need_set_reg_dep <= 1'b1;
                        bus.set_dep_reg_id   <= bus.ren_rd;
                        bus.set_dep_rob_id   <= bus.ren_rob_id;
                    end
                end
                MISP_WB: begin
                    state              <= FLUSH;
                    flush_cnt          <= '0;
                    bus.clear          <= 1'b1;
                    bus.redirect_valid <= 1'b1;
                    bus.redirect_pc    <= target_pc;
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state        <= RUN;
                        bus.clear    <= 1'b0;
                        bus.flushing <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_controller.sv
// Directed bench for commit_controller: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal expectations along the scenario.
module tb_commit_controller;

    localparam int FC = 2;

    logic clk;
    logic rst;
    int   nerr;
    int   nchk;
    logic chk_en;

    commit_controller_if #(.ROB_W(4)) bus ();

    commit_controller #(.FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: busy counts the remaining non-RUN cycles after a mispredict commit
    // (one writeback cycle followed by FC flush cycles).
    int          busy;
    int          m_was;
    logic [31:0] m_count;
    logic [31:0] m_tgt;
    logic        m_wr;
    logic [4:0]  m_wr_rd;
    logic [31:0] m_wr_val;
    logic [3:0]  m_wr_rob;
    logic        m_dep;
    logic [4:0]  m_dep_rd;
    logic [3:0]  m_dep_rob;

    initial begin
        busy = 0; m_count = 0; m_tgt = 0; m_wr = 0; m_dep = 0;
        m_wr_rd = 0; m_wr_val = 0; m_wr_rob = 0; m_dep_rd = 0; m_dep_rob = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            busy = 0; m_count = 0; m_wr = 0; m_dep = 0;
        end else if (bus.rdy) begin
            m_was = busy;
            m_wr  = 0;
            m_dep = 0;
            if (busy > 0) busy--;
            if (m_was == 0 && bus.head_valid && bus.head_ready) begin
                m_count = m_count + 1;
                if (bus.head_writes_rd && bus.head_rd != 5'd0) begin
                    m_wr = 1; m_wr_rd = bus.head_rd; m_wr_val = bus.head_value; m_wr_rob = bus.head_rob_id;
                end
                if (bus.head_mispredict) begin
                    busy  = FC + 1;
                    m_tgt = bus.head_target_pc;
                end
            end
            if (m_was == 0 && bus.ren_valid && bus.ren_rd != 5'd0) begin
                m_dep = 1; m_dep_rd = bus.ren_rd; m_dep_rob = bus.ren_rob_id;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("commit_ack", 32'(bus.commit_ack),
                32'(rst && bus.rdy && busy == 0 && bus.head_valid && bus.head_ready));
            chk("ren_ready", 32'(bus.ren_ready), 32'(rst && bus.rdy && busy == 0));
            chk("need_set_reg_value", 32'(bus.need_set_reg_value), 32'(m_wr));
            if (m_wr && bus.need_set_reg_value) begin
                chk("set_value_reg_id", 32'(bus.set_value_reg_id), 32'(m_wr_rd));
                chk("set_val", bus.set_val, m_wr_val);
                chk("set_reg_rob_id", 32'(bus.set_reg_rob_id), 32'(m_wr_rob));
            end
            chk("need_set_reg_dep", 32'(bus.need_set_reg_dep), 32'(m_dep));
            if (m_dep && bus.need_set_reg_dep) begin
                chk("set_dep_reg_id", 32'(bus.set_dep_reg_id), 32'(m_dep_rd));
                chk("set_dep_rob_id", 32'(bus.set_dep_rob_id), 32'(m_dep_rob));
            end
            chk("flushing", 32'(bus.flushing), 32'(busy > 0));
            chk("clear", 32'(bus.clear), 32'(busy >= 1 && busy <= FC));
            chk("redirect_valid", 32'(bus.redirect_valid), 32'(busy == FC));
            if (busy == FC) chk("redirect_pc", bus.redirect_pc, m_tgt);
            chk("commit_count", bus.commit_count, m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_head(input logic v, input logic r, input logic w, input logic [4:0] rd,
                            input logic [31:0] val, input logic [3:0] rob, input logic misp,
                            input logic [31:0] tgt);
        bus.head_valid = v; bus.head_ready = r; bus.head_writes_rd = w; bus.head_rd = rd;
        bus.head_value = val; bus.head_rob_id = rob; bus.head_mispredict = misp;
        bus.head_target_pc = tgt;
    endtask

    task automatic set_ren(input logic v, input logic [4:0] rd, input logic [3:0] rob);
        bus.ren_valid = v; bus.ren_rd = rd; bus.ren_rob_id = rob;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nerr = 0; nchk = 0; chk_en = 1'b0;
        rst = 1'b0; bus.rdy = 1'b1;
        // Reset held with traffic everywhere.
        set_head(1, 1, 1, 5'd5, 32'h1234, 4'd2, 1, 32'h8000);
        set_ren(1, 5'd3, 4'd4);
        tick;
        chk_en = 1'b1;
        tick; tick;
        #1;
        chk("rst_commit_ack", 32'(bus.commit_ack), 32'd0);
        chk("rst_ren_ready", 32'(bus.ren_ready), 32'd0);
        chk("rst_count", bus.commit_count, 32'd0);
        chk("rst_clear", 32'(bus.clear), 32'd0);
        chk("rst_wr", 32'(bus.need_set_reg_value), 32'd0);
        chk("rst_dep", 32'(bus.need_set_reg_dep), 32'd0);

        rst = 1'b1;
        set_head(0, 0, 0, 5'd0, 32'd0, 4'd0, 0, 32'd0);
        set_ren(0, 5'd0, 4'd0);
        #1 chk("rel_ren_ready", 32'(bus.ren_ready), 32'd1);
        tick;

        // Normal commit.
        set_head(1, 1, 1, 5'd5, 32'hDEADBEEF, 4'd3, 0, 32'd0);
        #1 chk("norm_ack", 32'(bus.commit_ack), 32'd1);
        tick;
        chk("norm_wr", 32'(bus.need_set_reg_value), 32'd1);
        chk("norm_rd", 32'(bus.set_value_reg_id), 32'd5);
        chk("norm_val", bus.set_val, 32'hDEADBEEF);
        chk("norm_rob", 32'(bus.set_reg_rob_id), 32'd3);
        chk("norm_count", bus.commit_count, 32'd1);

        // Head present but result not ready, then x0 and no-rd commits.
        set_head(1, 0, 1, 5'd6, 32'd1, 4'd0, 0, 32'd0);
        #1 chk("notready_ack", 32'(bus.commit_ack), 32'd0);
        tick;
        set_head(1, 1, 1, 5'd0, 32'd7, 4'd1, 0, 32'd0);
        tick;
        chk("x0_wr", 32'(bus.need_set_reg_value), 32'd0);
        set_head(1, 1, 0, 5'd4, 32'd9, 4'd2, 0, 32'd0);
        tick;
        chk("nord_wr", 32'(bus.need_set_reg_value), 32'd0);
        chk("nord_count", bus.commit_count, 32'd3);

        // Mispredicted jalr.
        set_head(1, 1, 1, 5'd1, 32'h100, 4'd4, 1, 32'h2000);
        tick;
        chk("misp_wr", 32'(bus.need_set_reg_value), 32'd1);
        chk("misp_rd", 32'(bus.set_value_reg_id), 32'd1);
        chk("misp_val", bus.set_val, 32'h100);
        chk("misp_wb_clear", 32'(bus.clear), 32'd0);
        chk("misp_flushing", 32'(bus.flushing), 32'd1);
        chk("misp_count", bus.commit_count, 32'd4);
        set_head(1, 1, 1, 5'd2, 32'h55, 4'd5, 0, 32'd0);
        set_ren(1, 5'd8, 4'd6);
        #1;
        chk("wb_ack", 32'(bus.commit_ack), 32'd0);
        chk("wb_ren_ready", 32'(bus.ren_ready), 32'd0);
        tick;
        chk("fl1_clear", 32'(bus.clear), 32'd1);
        chk("fl1_redir", 32'(bus.redirect_valid), 32'd1);
        chk("fl1_pc", bus.redirect_pc, 32'h2000);
        chk("fl1_wr", 32'(bus.need_set_reg_value), 32'd0);
        tick;
        chk("fl2_clear", 32'(bus.clear), 32'd1);
        chk("fl2_redir", 32'(bus.redirect_valid), 32'd0);
        tick;
        chk("post_clear", 32'(bus.clear), 32'd0);
        chk("post_flushing", 32'(bus.flushing), 32'd0);
        chk("post_ack", 32'(bus.commit_ack), 32'd1);
        tick;
        chk("post_wr_rd", 32'(bus.set_value_reg_id), 32'd2);
        chk("post_dep", 32'(bus.need_set_reg_dep), 32'd1);
        chk("post_dep_rd", 32'(bus.set_dep_reg_id), 32'd8);
        chk("post_count", bus.commit_count, 32'd5);

        // Same-rd commit and rename.
        set_head(1, 1, 1, 5'd7, 32'h77, 4'd2, 0, 32'd0);
        set_ren(1, 5'd7, 4'd9);
        tick;
        chk("col_wr", 32'(bus.need_set_reg_value), 32'd1);
        chk("col_dep", 32'(bus.need_set_reg_dep), 32'd1);
        chk("col_wr_rob", 32'(bus.set_reg_rob_id), 32'd2);
        chk("col_dep_rob", 32'(bus.set_dep_rob_id), 32'd9);
        set_ren(0, 5'd0, 4'd0);

        // rdy low in RUN freezes everything, pulses included.
        set_head(1, 1, 1, 5'd3, 32'h33, 4'd1, 0, 32'd0);
        bus.rdy = 1'b0;
        #1 chk("stall_ack", 32'(bus.commit_ack), 32'd0);
        tick; tick;
        chk("stall_count", bus.commit_count, 32'd6);
        chk("stall_hold_wr", 32'(bus.need_set_reg_value), 32'd1);
        bus.rdy = 1'b1;
        tick;
        chk("unstall_count", bus.commit_count, 32'd7);
        chk("unstall_rd", 32'(bus.set_value_reg_id), 32'd3);

        // Stall inside FLUSH.
        set_head(1, 1, 0, 5'd0, 32'd0, 4'd7, 1, 32'h3000);
        tick;
        chk("g_wr", 32'(bus.need_set_reg_value), 32'd0);
        chk("g_count", bus.commit_count, 32'd8);
        set_head(0, 0, 0, 5'd0, 32'd0, 4'd0, 0, 32'd0);
        tick;
        chk("g_fl1_pc", bus.redirect_pc, 32'h3000);
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("g_hold_clear", 32'(bus.clear), 32'd1);
            chk("g_hold_redir", 32'(bus.redirect_valid), 32'd1);
        end
        bus.rdy = 1'b1;
        tick;
        chk("g_fl2_clear", 32'(bus.clear), 32'd1);
        chk("g_fl2_redir", 32'(bus.redirect_valid), 32'd0);
        tick;
        chk("g_run_clear", 32'(bus.clear), 32'd0);

        // Reset in the middle of a flush.
        set_head(1, 1, 1, 5'd9, 32'h99, 4'd3, 1, 32'h4000);
        tick;
        set_head(0, 0, 0, 5'd0, 32'd0, 4'd0, 0, 32'd0);
        tick;
        chk("h_fl1_clear", 32'(bus.clear), 32'd1);
        rst = 1'b0;
        tick;
        chk("h_rst_clear", 32'(bus.clear), 32'd0);
        chk("h_rst_flushing", 32'(bus.flushing), 32'd0);
        chk("h_rst_count", bus.commit_count, 32'd0);
        rst = 1'b1;
        #1 chk("h_ren_ready", 32'(bus.ren_ready), 32'd1);
        set_head(1, 1, 1, 5'd31, 32'hCAFE0001, 4'd15, 0, 32'd0);
        tick;
        chk("h_wr_rd", 32'(bus.set_value_reg_id), 32'd31);
        chk("h_count", bus.commit_count, 32'd1);
        set_head(0, 0, 0, 5'd0, 32'd0, 4'd0, 0, 32'd0);
        tick;

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
